// File: rtl/taylor_pkg.sv
// Shared constants and the driver state type for the Taylor cosine engine host logic.
// Angles are unsigned Q.10 radians, results signed Q.10.
package taylor_pkg;

   localparam int FXP_SHIFT = 10;
   localparam int FXP_MUL   = 1 << FXP_SHIFT;

   localparam int PI    = 3217;
   localparam int PI_2  = 1608;
   localparam int PI3_2 = 4825;
   localparam int PI2   = 6434;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REDUCE,
      ST_LAUNCH,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_RELEASE,
      ST_OUTPUT
   } drv_state_e;

endpackage

// File: rtl/taylor_range_reduce.sv
// Folds an unsigned Q.10 angle in [0, 2*PI) onto [0, PI/2] and reports whether
// the cosine of the original angle is negative. Built only with TAYLOR_RANGE_REDUCE_EN.
module taylor_range_reduce
   import taylor_pkg::*;
#(
   parameter int W = 24
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] r,
   output logic         neg,
   output logic         oor
);

   localparam logic [W-1:0] K_PI    = W'(PI);
   localparam logic [W-1:0] K_PI_2  = W'(PI_2);
   localparam logic [W-1:0] K_PI3_2 = W'(PI3_2);
   localparam logic [W-1:0] K_PI2   = W'(PI2);

   always_comb begin
      r   = '0;
      neg = 1'b0;
      oor = 1'b0;
      if (x < K_PI_2) begin
         r = x;
      end else if (x < K_PI) begin
         r   = K_PI - x;
         neg = 1'b1;
      end else if (x < K_PI3_2) begin
         r   = x - K_PI;
         neg = 1'b1;
      end else if (x < K_PI2) begin
         r = K_PI2 - x;
      end else begin
         oor = 1'b1;
      end
   end

endmodule

// File: rtl/taylor_cos_driver.sv
// Host-side sequencer for the Taylor cosine engine: request port, engine start/ready
// handshake with timeout, quadrant sign fix-up and result port. Quadrant folding is
// compiled in with TAYLOR_RANGE_REDUCE_EN; without it the angle is passed through.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | req_ready high, waiting for an angle
// ST_REDUCE    | register folded angle and sign; out-of-range goes to OUTPUT
// ST_LAUNCH    | first cycle of eng_start
// ST_WAIT_ACK  | keep eng_start high until the engine drops a stale ready
// ST_WAIT_DONE | eng_start low, wait for ready and capture the result
// ST_RELEASE   | one start pulse to return the engine from done to idle
// ST_OUTPUT    | res_valid high until res_ready
module taylor_cos_driver
   import taylor_pkg::*;
#(
   parameter int W         = 24,
   parameter int FXP_SHIFT = 10,
   parameter int TIMEOUT   = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] req_angle,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_data,
   output logic         res_err,
   output logic         eng_start,
   output logic [W-1:0] eng_angle,
   input  logic         eng_ready,
   input  logic [W-1:0] eng_result
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   drv_state_e   state_q;
   drv_state_e   state_d;
   logic [W-1:0] angle_q;
   logic         neg_q;
   logic [7:0]   tmo_q;
   logic         tmo_hit;
   logic         accept;
   logic [W-1:0] red_r;
   logic         red_neg;
   logic         red_oor;

   // The folding constants are fixed Q.10 values and PI2 needs 13 integer+fraction bits.
   if (FXP_SHIFT != taylor_pkg::FXP_SHIFT || W < 14) begin : g_cfg_check
      $error("taylor_cos_driver: angle constants are Q.10 and need W >= 14");
   end

`ifdef TAYLOR_RANGE_REDUCE_EN
   taylor_range_reduce #(
      .W (W)
   ) u_range_reduce (
      .x   (angle_q),
      .r   (red_r),
      .neg (red_neg),
      .oor (red_oor)
   );
`else
   assign red_r   = angle_q;
   assign red_neg = 1'b0;
   assign red_oor = 1'b0;
`endif

   assign tmo_hit = (tmo_q == TMO_LIMIT);
   assign accept  = req_valid && req_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_REDUCE;
         end
         ST_REDUCE: begin
            state_d = red_oor ? ST_OUTPUT : ST_LAUNCH;
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (tmo_hit)         state_d = ST_OUTPUT;
            else if (!eng_ready) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (tmo_hit)        state_d = ST_OUTPUT;
            else if (eng_ready) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            state_d = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs are registered from the next state so they line up with it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req_ready <= 1'b0;
         res_valid <= 1'b0;
         eng_start <= 1'b0;
      end else begin
         req_ready <= (state_d == ST_IDLE);
         res_valid <= (state_d == ST_OUTPUT);
         eng_start <= (state_d == ST_LAUNCH) || (state_d == ST_WAIT_ACK) ||
                      (state_d == ST_RELEASE);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         angle_q   <= '0;
         neg_q     <= 1'b0;
         tmo_q     <= '0;
         eng_angle <= '0;
         res_data  <= '0;
         res_err   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) angle_q <= req_angle;
            end
            ST_REDUCE: begin
               if (red_oor) begin
                  res_data <= '0;
                  res_err  <= 1'b1;
               end else begin
                  eng_angle <= red_r;
                  neg_q     <= red_neg;
                  tmo_q     <= '0;
               end
            end
            ST_WAIT_ACK, ST_WAIT_DONE: begin
               if (tmo_hit) begin
                  res_data <= '0;
                  res_err  <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
                  if (state_q == ST_WAIT_DONE && eng_ready) begin
                     res_data <= neg_q ? -eng_result : eng_result;
                     res_err  <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_taylor_cos_driver.sv
// Directed bench for taylor_cos_driver with a behavioural engine stub
// (IDLE, LOAD, S1..S3, DONE; compute starts once start is released).
module tb_taylor_cos_driver;

   localparam int W = 24;

`ifdef TAYLOR_RANGE_REDUCE_EN
   localparam logic [W-1:0] EXP_E2000 = 24'd1217;
   localparam logic [W-1:0] EXP_D2000 = 24'hFFFB3F;
   localparam logic [W-1:0] EXP_D3217 = 24'd0;
   localparam logic [W-1:0] EXP_D6000 = 24'd434;
   localparam logic [W-1:0] EXP_D4000 = 24'hFFFCF1;
`else
   localparam logic [W-1:0] EXP_E2000 = 24'd2000;
   localparam logic [W-1:0] EXP_D2000 = 24'd2000;
   localparam logic [W-1:0] EXP_D3217 = 24'd3217;
   localparam logic [W-1:0] EXP_D6000 = 24'd6000;
   localparam logic [W-1:0] EXP_D4000 = 24'd4000;
`endif

   logic         clock;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_angle;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;
   logic         res_err;
   logic         eng_start;
   logic [W-1:0] eng_angle;
   logic         eng_ready;
   logic [W-1:0] eng_result;

   logic         eng_rst_n;
   logic         stub_hang;
   logic         stub_real;

   int checks;
   int failures;
   int lat;
   logic st;

   taylor_cos_driver #(.W(W), .FXP_SHIFT(10), .TIMEOUT(64)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_angle  (req_angle),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_err    (res_err),
      .eng_start  (eng_start),
      .eng_angle  (eng_angle),
      .eng_ready  (eng_ready),
      .eng_result (eng_result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef enum logic [2:0] {E_IDLE, E_LOAD, E_S1, E_S2, E_S3, E_DONE} eng_st_e;
   eng_st_e      e_st;
   logic [W-1:0] e_angle;

   always_ff @(posedge clock or negedge eng_rst_n) begin
      if (!eng_rst_n) begin
         e_st    <= E_IDLE;
         e_angle <= '0;
      end else begin
         case (e_st)
            E_IDLE:  if (eng_start) e_st <= E_LOAD;
            E_LOAD:  if (!eng_start) begin
                        e_st    <= E_S1;
                        e_angle <= eng_angle;
                     end
            E_S1:    e_st <= E_S2;
            E_S2:    e_st <= E_S3;
            E_S3:    if (!stub_hang) e_st <= E_DONE;
            E_DONE:  if (eng_start) e_st <= E_IDLE;
            default: e_st <= E_IDLE;
         endcase
      end
   end

   function automatic logic [W-1:0] ref_cos(input logic [W-1:0] a);
      longint x, x2, x4, c;
      x  = longint'(a);
      x2 = (x * x) >>> 10;
      x4 = (x2 * x2) >>> 10;
      c  = 1024 - x2 / 2 + x4 / 24;
      return c[W-1:0];
   endfunction

   assign eng_ready  = (e_st == E_DONE);
   assign eng_result = stub_real ? ref_cos(e_angle) : e_angle;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns cycles from the accept cycle to the first res_valid.
   task automatic run_req(input logic [W-1:0] a, output int l, output logic start_seen);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_angle = a;
      while (!req_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("req_accept", 32'(req_ready), 32'd1);
      l = 0;
      start_seen = 1'b0;
      do begin
         @(negedge clock);
         req_valid = 1'b0;
         l++;
         if (eng_start) start_seen = 1'b1;
      end while (!res_valid && l < 200);
      check("res_wait_bound", 32'(res_valid), 32'd1);
   endtask

   task automatic take_res(input string tag, input logic [W-1:0] d, input logic e);
      check({tag, "_data"}, 32'(res_data), 32'(d));
      check({tag, "_err"}, 32'(res_err), 32'(e));
      res_ready = 1'b1;
      @(negedge clock);
      res_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b0;
      eng_rst_n = 1'b0;
      req_valid = 1'b0;
      req_angle = '0;
      res_ready = 1'b0;
      stub_hang = 1'b0;
      stub_real = 1'b0;

      repeat (3) @(negedge clock);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_res_err", 32'(res_err), 32'd0);
      check("rst_eng_start", 32'(eng_start), 32'd0);
      check("rst_eng_angle", 32'(eng_angle), 32'd0);
      reset     = 1'b1;
      eng_rst_n = 1'b1;
      #1;
      check("req_ready_pre_edge", 32'(req_ready), 32'd0);
      @(negedge clock);
      check("req_ready_after_rst", 32'(req_ready), 32'd1);

      // angle 0 through the Taylor model, engine ready starts low
      stub_real = 1'b1;
      run_req(24'd0, lat, st);
      check("a0_latency", 32'(lat), 32'd10);
      take_res("a0", 24'd1024, 1'b0);
      stub_real = 1'b0;

      run_req(24'd2000, lat, st);
      check("a2000_latency", 32'(lat), 32'd10);
      check("a2000_eng_angle", 32'(eng_angle), 32'(EXP_E2000));
      take_res("a2000", EXP_D2000, 1'b0);

      run_req(24'd3217, lat, st);
      take_res("a3217", EXP_D3217, 1'b0);

      run_req(24'd6000, lat, st);
      check("a6000_latency", 32'(lat), 32'd10);
      take_res("a6000", EXP_D6000, 1'b0);

      run_req(24'd7000, lat, st);
`ifdef TAYLOR_RANGE_REDUCE_EN
      check("a7000_latency", 32'(lat), 32'd2);
      check("a7000_no_start", 32'(st), 32'd0);
      check("a7000_eng_angle_held", 32'(eng_angle), 32'd434);
      take_res("a7000", 24'd0, 1'b1);
`else
      check("a7000_latency", 32'(lat), 32'd10);
      check("a7000_start", 32'(st), 32'd1);
      take_res("a7000", 24'd7000, 1'b0);
`endif

      // engine never completes: timeout after 64 wait cycles
      stub_hang = 1'b1;
      run_req(24'd100, lat, st);
      check("tmo_latency", 32'(lat), 32'd68);
      take_res("tmo", 24'd0, 1'b1);
      stub_hang = 1'b0;
      repeat (2) @(negedge clock);

      // engine now sits in done with a stale ready
      run_req(24'd500, lat, st);
      check("stale_latency", 32'(lat), 32'd10);
      take_res("stale", 24'd500, 1'b0);

      // back-pressure with the next request already pending
      run_req(24'd1000, lat, st);
      check("bp_latency", 32'(lat), 32'd10);
      req_valid = 1'b1;
      req_angle = 24'd1500;
      for (int i = 0; i < 5; i++) begin
         check("bp_res_valid", 32'(res_valid), 32'd1);
         check("bp_res_data", 32'(res_data), 32'd1000);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         @(negedge clock);
      end
      check("bp_req_ready_hs", 32'(req_ready), 32'd0);
      take_res("bp", 24'd1000, 1'b0);
      check("b2b_req_ready", 32'(req_ready), 32'd1);
      run_req(24'd1500, lat, st);
      check("b2b_latency", 32'(lat), 32'd10);
      take_res("b2b", 24'd1500, 1'b0);

      // reset while waiting for the engine result
      req_valid = 1'b1;
      req_angle = 24'd300;
      check("mid_req_ready", 32'(req_ready), 32'd1);
      @(negedge clock);
      req_valid = 1'b0;
      repeat (4) @(negedge clock);
      check("mid_wait_done_start", 32'(eng_start), 32'd0);
      check("mid_wait_done_valid", 32'(res_valid), 32'd0);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_req_ready", 32'(req_ready), 32'd0);
      check("mid_rst_res_valid", 32'(res_valid), 32'd0);
      check("mid_rst_res_data", 32'(res_data), 32'd0);
      check("mid_rst_res_err", 32'(res_err), 32'd0);
      check("mid_rst_eng_start", 32'(eng_start), 32'd0);
      check("mid_rst_eng_angle", 32'(eng_angle), 32'd0);
      repeat (12) @(negedge clock);
      reset = 1'b1;
      #1;
      check("mid_req_ready_pre_edge", 32'(req_ready), 32'd0);
      @(negedge clock);
      check("mid_req_ready_after", 32'(req_ready), 32'd1);
      run_req(24'd4000, lat, st);
      check("post_rst_latency", 32'(lat), 32'd10);
      take_res("post_rst", EXP_D4000, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
